// File: rtl/cl_dram_scrb_engine.sv
// ---------------------------------------------------------------------------
// cl_dram_scrb_engine
//   DRAM scrubber / fill engine. Writes a 64-bit pattern, replicated across
//   the data bus, over the byte range [cfg_start, cfg_end) using full AXI4
//   write bursts of BURST_LEN beats plus one short final burst if needed.
//   AW and W are issued strictly in order, one burst at a time, with up to
//   MAX_OUT bursts awaiting their B response.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              level: start a run from IDLE, low aborts / acks DONE
//   cfg_start/cfg_end   byte range, end exclusive
//   pattern             64-bit fill pattern
//   addr                byte address of the next burst to issue
//   state               0 IDLE, 1 ADDR, 2 DATA, 3 DRAIN, 4 DONE
//   done                high in DONE
//   err                 sticky, set on any non-OKAY bresp during a run
//   aw*/w*/b*           AXI4 write master channels
// ---------------------------------------------------------------------------
module cl_dram_scrb_engine #(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned ID_W      = 16,
    parameter int unsigned SCRB_ID   = 0,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned MAX_OUT   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   cfg_start,
    input  logic [ADDR_W-1:0]   cfg_end,
    input  logic [63:0]         pattern,
    output logic [ADDR_W-1:0]   addr,
    output logic [2:0]          state,
    output logic                done,
    output logic                err,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int unsigned BEAT_BYTES = DATA_W / 8;
    localparam int unsigned SIZE_LOG   = $clog2(BEAT_BYTES);
    localparam int unsigned LANES      = DATA_W / 64;

    if (BURST_LEN < 1 || BURST_LEN > 256 || BURST_LEN * BEAT_BYTES > 4096 ||
        MAX_OUT < 1 || MAX_OUT > 255 || DATA_W < 64 || DATA_W > 512 ||
        (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_cfg
        $error("cl_dram_scrb_engine: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, end_q;
    logic [63:0]         pattern_q;
    logic [8:0]          beat_cnt;
    logic [7:0]          out_cnt;
    logic                aw_shown;
    logic                abort_q;
    logic                err_q;

    logic                start_run;
    logic                aw_hs, w_hs, b_hs;
    logic [ADDR_W-1:0]   rem_bytes, rem_beats, burst_bytes;
    logic [8:0]          burst_beats, burst_len_m1;

    logic unused_ok;
    assign unused_ok = ^bid;

    assign rem_bytes    = end_q - addr_q;
    assign rem_beats    = rem_bytes >> SIZE_LOG;
    assign burst_beats  = (rem_beats >= ADDR_W'(BURST_LEN)) ? 9'(BURST_LEN) : rem_beats[8:0];
    assign burst_len_m1 = burst_beats - 9'd1;
    assign burst_bytes  = ADDR_W'(burst_beats) << SIZE_LOG;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign bready = !rst;
    assign b_hs   = bvalid && bready;

    assign addr  = addr_q;
    assign state = state_q;
    assign done  = (state_q == S_DONE);
    assign err   = err_q;

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        awvalid   = 1'b0;
        awid      = '0;
        awaddr    = '0;
        awlen     = '0;
        awsize    = '0;
        wvalid    = 1'b0;
        wid       = '0;
        wdata     = '0;
        wstrb     = '0;
        wlast     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    start_run = 1'b1;
                    state_d   = (cfg_end <= cfg_start) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                // Once awvalid has been shown without a handshake it must stay
                // up, so a late enable drop cannot retract it; abort only
                // happens from a cycle where awvalid was never presented.
                awvalid = (32'(out_cnt) < MAX_OUT) && (enable || aw_shown);
                awid    = ID_W'(SCRB_ID);
                awaddr  = addr_q;
                awlen   = burst_len_m1[7:0];
                awsize  = 3'(SIZE_LOG);
                if (awvalid && awready)
                    state_d = S_DATA;
                else if (!enable && !aw_shown)
                    state_d = S_DRAIN;
            end
            S_DATA: begin
                wvalid = 1'b1;
                wid    = ID_W'(SCRB_ID);
                wstrb  = '1;
                wlast  = (beat_cnt == 9'd1);
                for (int unsigned i = 0; i < LANES; i++)
                    wdata[i*64 +: 64] = pattern_q;
                if (wready && wlast)
                    state_d = (addr_q < end_q && enable && !abort_q) ? S_ADDR : S_DRAIN;
            end
            S_DRAIN: begin
                if (out_cnt == 8'd0)
                    state_d = (addr_q >= end_q) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!enable)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            end_q     <= '0;
            pattern_q <= '0;
            beat_cnt  <= '0;
            out_cnt   <= '0;
            aw_shown  <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_shown <= awvalid && !awready;

            if (start_run) begin
                addr_q    <= cfg_start;
                end_q     <= cfg_end;
                pattern_q <= pattern;
            end else if (aw_hs) begin
                addr_q <= addr_q + burst_bytes;
            end

            if (aw_hs)
                beat_cnt <= burst_beats;
            else if (w_hs)
                beat_cnt <= beat_cnt - 9'd1;

            // Remember an enable drop anywhere inside a burst, not just at wlast.
            if (start_run)
                abort_q <= 1'b0;
            else if (state_q == S_DATA && !enable)
                abort_q <= 1'b1;

            unique case ({aw_hs, b_hs && (out_cnt != 8'd0)})
                2'b10:   out_cnt <= out_cnt + 8'd1;
                2'b01:   out_cnt <= out_cnt - 8'd1;
                default: out_cnt <= out_cnt;
            endcase

            if (start_run)
                err_q <= 1'b0;
            else if (b_hs && bresp != 2'b00)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cl_dram_scrb_engine.sv
// ---------------------------------------------------------------------------
// tb_cl_dram_scrb_engine
//   Self-checking bench for cl_dram_scrb_engine (DATA_W=512, BURST_LEN=8,
//   MAX_OUT=2). A behavioural AXI slave logs every AW/W handshake and returns
//   one B per completed burst; a burst-list model derived from the range
//   arithmetic supplies the expected addresses, lengths and beat counts.
// ---------------------------------------------------------------------------
module tb_cl_dram_scrb_engine;

    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int IDW = 16;
    localparam int BL  = 8;
    localparam int MO  = 2;
    localparam int BB  = DW / 8;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [AW-1:0] cfg_start = '0, cfg_end = '0;
    logic [63:0]   pattern = '0;
    logic [AW-1:0] addr;
    logic [2:0]    state;
    logic          done, err;
    logic [IDW-1:0] awid, wid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic          awvalid, wlast, wvalid, bready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic [IDW-1:0] bid = '0;

    always #5 clk = ~clk;

    cl_dram_scrb_engine #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IDW), .SCRB_ID(0),
                          .BURST_LEN(BL), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_start(cfg_start), .cfg_end(cfg_end),
        .pattern(pattern), .addr(addr), .state(state), .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
        .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready));

    int pass_cnt = 0, chk_cnt = 0;

    // slave / monitor state
    bit rand_bp = 0, b_release = 1, bad_first = 0;
    int b_pending = 0, b_seen = 0, out_cnt = 0, max_out = 0;
    logic [AW-1:0]   aw_addr_log[$];
    int              aw_len_log[$];
    logic [DW-1:0]   w_data_log[$];
    logic [DW/8-1:0] w_strb_log[$];
    bit              w_last_log[$];

    // model output
    logic [AW-1:0] exp_addr[$];
    int            exp_len[$];
    int            exp_beats;

    initial begin : slave
        bit aw_s, w_s, b_s, last_s;
        forever begin
            @(negedge clk);
            aw_s = awvalid && awready;
            w_s  = wvalid && wready;
            last_s = wlast;
            b_s  = bvalid && bready;
            if (aw_s) begin aw_addr_log.push_back(awaddr); aw_len_log.push_back(int'(awlen)); end
            if (w_s) begin w_data_log.push_back(wdata); w_strb_log.push_back(wstrb); w_last_log.push_back(wlast); end
            @(posedge clk);
            #1;
            if (rst) begin
                b_pending = 0; out_cnt = 0;
            end else begin
                if (aw_s) out_cnt++;
                if (b_s) out_cnt--;
                if (out_cnt > max_out) max_out = out_cnt;
                if (w_s && last_s) b_pending++;
                if (b_s) begin b_pending--; b_seen++; end
            end
            bvalid  = b_release && (b_pending > 0);
            bresp   = (bad_first && b_seen == 0) ? 2'b10 : 2'b00;
            awready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected burst list: full bursts from the start, one short tail burst.
    task automatic model_run(input logic [AW-1:0] s, input logic [AW-1:0] e);
        logic [AW-1:0] a;
        int rem, n;
        exp_addr.delete(); exp_len.delete(); exp_beats = 0;
        a = s;
        while (a < e) begin
            rem = int'((e - a) / BB);
            n = (rem > BL) ? BL : rem;
            exp_addr.push_back(a);
            exp_len.push_back(n - 1);
            exp_beats += n;
            a = a + AW'(n * BB);
        end
    endtask

    task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [63:0] p);
        aw_addr_log.delete(); aw_len_log.delete();
        w_data_log.delete(); w_strb_log.delete(); w_last_log.delete();
        b_seen = 0; max_out = 0;
        cfg_start = s; cfg_end = e; pattern = p;
        enable = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin to = 1'b0; break; end
        end
    endtask

    task automatic finish_run();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk_cnt++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else pass_cnt++;
        chk_cnt++; if (awvalid !== 1'b0) $display("FAIL reset_awvalid got=%0b exp=0", awvalid); else pass_cnt++;
        chk_cnt++; if (wvalid !== 1'b0) $display("FAIL reset_wvalid got=%0b exp=0", wvalid); else pass_cnt++;
        chk_cnt++; if (bready !== 1'b0) $display("FAIL reset_bready got=%0b exp=0", bready); else pass_cnt++;
        chk_cnt++; if (addr !== '0) $display("FAIL reset_addr got=%0h exp=0", addr); else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++; if (bready !== 1'b1) $display("FAIL run_bready got=%0b exp=1", bready); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL idle_state got=%0d exp=0", state); else pass_cnt++;
    endtask

    task automatic test_basic();
        bit to;
        model_run(64'h1000, 64'h1400);
        start_run(64'h1000, 64'h1400, {$urandom, $urandom});
        wait_done(300, to);
        chk_cnt++; if (to !== 1'b0) $display("FAIL basic_timeout got=%0b exp=0", to); else pass_cnt++;
        chk_cnt++; if (aw_addr_log.size() !== exp_addr.size()) $display("FAIL basic_aw_count got=%0d exp=%0d", aw_addr_log.size(), exp_addr.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr.size() && i < aw_addr_log.size(); i++) begin
            chk_cnt++; if (aw_addr_log[i] !== exp_addr[i]) $display("FAIL basic_awaddr[%0d] got=%0h exp=%0h", i, aw_addr_log[i], exp_addr[i]); else pass_cnt++;
            chk_cnt++; if (aw_len_log[i] !== exp_len[i]) $display("FAIL basic_awlen[%0d] got=%0d exp=%0d", i, aw_len_log[i], exp_len[i]); else pass_cnt++;
        end
        chk_cnt++; if (w_data_log.size() !== exp_beats) $display("FAIL basic_beats got=%0d exp=%0d", w_data_log.size(), exp_beats); else pass_cnt++;
        chk_cnt++; if (done !== 1'b1) $display("FAIL basic_done got=%0b exp=1", done); else pass_cnt++;
        finish_run();
        chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_drop got=%0b exp=0", done); else pass_cnt++;
    endtask

    task automatic test_short_burst();
        bit to;
        int b;
        model_run(64'h0, 64'h240);
        start_run(64'h0, 64'h240, 64'h0123_4567_89AB_CDEF);
        wait_done(300, to);
        chk_cnt++; if (to !== 1'b0) $display("FAIL short_timeout got=%0b exp=0", to); else pass_cnt++;
        chk_cnt++; if (aw_addr_log.size() !== exp_addr.size()) $display("FAIL short_aw_count got=%0d exp=%0d", aw_addr_log.size(), exp_addr.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr.size() && i < aw_addr_log.size(); i++) begin
            chk_cnt++; if (aw_addr_log[i] !== exp_addr[i]) $display("FAIL short_awaddr[%0d] got=%0h exp=%0h", i, aw_addr_log[i], exp_addr[i]); else pass_cnt++;
            chk_cnt++; if (aw_len_log[i] !== exp_len[i]) $display("FAIL short_awlen[%0d] got=%0d exp=%0d", i, aw_len_log[i], exp_len[i]); else pass_cnt++;
        end
        chk_cnt++; if (w_last_log.size() !== exp_beats) $display("FAIL short_beats got=%0d exp=%0d", w_last_log.size(), exp_beats); else pass_cnt++;
        b = 0;
        for (int j = 0; j < exp_len.size(); j++)
            for (int t = 0; t <= exp_len[j]; t++) begin
                if (b < w_last_log.size()) begin
                    chk_cnt++; if (w_last_log[b] !== (t == exp_len[j])) $display("FAIL short_wlast[%0d] got=%0b exp=%0b", b, w_last_log[b], (t == exp_len[j])); else pass_cnt++;
                end
                b++;
            end
        chk_cnt++; if (err !== 1'b0) $display("FAIL short_err got=%0b exp=0", err); else pass_cnt++;
        finish_run();
    endtask

    task automatic test_max_outstanding();
        bit to;
        b_release = 0;
        model_run(64'h0, 64'h800);
        start_run(64'h0, 64'h800, 64'h5555_AAAA_5555_AAAA);
        repeat (60) tick();
        chk_cnt++; if (aw_addr_log.size() !== MO) $display("FAIL maxout_stall_aw got=%0d exp=%0d", aw_addr_log.size(), MO); else pass_cnt++;
        chk_cnt++; if (state !== 3'd1) $display("FAIL maxout_stall_state got=%0d exp=1", state); else pass_cnt++;
        chk_cnt++; if (awvalid !== 1'b0) $display("FAIL maxout_stall_awvalid got=%0b exp=0", awvalid); else pass_cnt++;
        b_release = 1;
        wait_done(500, to);
        chk_cnt++; if (to !== 1'b0) $display("FAIL maxout_timeout got=%0b exp=0", to); else pass_cnt++;
        chk_cnt++; if (aw_addr_log.size() !== exp_addr.size()) $display("FAIL maxout_aw_count got=%0d exp=%0d", aw_addr_log.size(), exp_addr.size()); else pass_cnt++;
        chk_cnt++; if (w_data_log.size() !== exp_beats) $display("FAIL maxout_beats got=%0d exp=%0d", w_data_log.size(), exp_beats); else pass_cnt++;
        chk_cnt++; if (max_out > MO) $display("FAIL maxout_peak got=%0d exp<=%0d", max_out, MO); else pass_cnt++;
        finish_run();
    endtask

    task automatic test_pattern();
        bit to;
        logic [63:0] pats[2];
        logic [DW-1:0] exp_w;
        pats[0] = 64'hDEADBEEF_01234567;
        pats[1] = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < DW / 64; l++) exp_w[l*64 +: 64] = pats[k];
            start_run(64'h2000, 64'h2400, pats[k]);
            wait_done(300, to);
            chk_cnt++; if (to !== 1'b0) $display("FAIL pattern_timeout got=%0b exp=0", to); else pass_cnt++;
            chk_cnt++; if (w_data_log.size() !== 16) $display("FAIL pattern_beats got=%0d exp=16", w_data_log.size()); else pass_cnt++;
            for (int i = 0; i < w_data_log.size(); i++) begin
                chk_cnt++; if (w_data_log[i] !== exp_w) $display("FAIL pattern_wdata[%0d] got=%0h exp=%0h", i, w_data_log[i][63:0], pats[k]); else pass_cnt++;
                chk_cnt++; if (w_strb_log[i] !== {(DW/8){1'b1}}) $display("FAIL pattern_wstrb[%0d] got=%0h exp=all-ones", i, w_strb_log[i]); else pass_cnt++;
            end
            finish_run();
        end
    endtask

    task automatic test_abort();
        bit to;
        start_run(64'h0, 64'h1000, 64'h1111_2222_3333_4444);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (w_data_log.size() >= 2) begin to = 1'b0; break; end
        end
        enable = 1'b0;
        chk_cnt++; if (to !== 1'b0) $display("FAIL abort_reach_beat got=%0b exp=0", to); else pass_cnt++;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (state == 3'd0) begin to = 1'b0; break; end
        end
        repeat (5) tick();
        chk_cnt++; if (to !== 1'b0) $display("FAIL abort_timeout got=%0b exp=0", to); else pass_cnt++;
        chk_cnt++; if (aw_addr_log.size() !== 1) $display("FAIL abort_aw_count got=%0d exp=1", aw_addr_log.size()); else pass_cnt++;
        chk_cnt++; if (w_data_log.size() !== BL) $display("FAIL abort_beats got=%0d exp=%0d", w_data_log.size(), BL); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL abort_state got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL abort_done got=%0b exp=0", done); else pass_cnt++;
    endtask

    task automatic test_err();
        bit to;
        bad_first = 1;
        start_run(64'h0, 64'h400, 64'h0);
        wait_done(300, to);
        chk_cnt++; if (to !== 1'b0) $display("FAIL err_timeout got=%0b exp=0", to); else pass_cnt++;
        chk_cnt++; if (err !== 1'b1) $display("FAIL err_set got=%0b exp=1", err); else pass_cnt++;
        finish_run();
        chk_cnt++; if (err !== 1'b1) $display("FAIL err_sticky got=%0b exp=1", err); else pass_cnt++;
        bad_first = 0;
        start_run(64'h0, 64'h400, 64'h0);
        wait_done(300, to);
        chk_cnt++; if (to !== 1'b0) $display("FAIL err2_timeout got=%0b exp=0", to); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL err_cleared got=%0b exp=0", err); else pass_cnt++;
        finish_run();
    endtask

    task automatic test_empty();
        start_run(64'h4000, 64'h4000, 64'hFFFF);
        tick();
        chk_cnt++; if (state !== 3'd4) $display("FAIL empty_state got=%0d exp=4", state); else pass_cnt++;
        chk_cnt++; if (done !== 1'b1) $display("FAIL empty_done got=%0b exp=1", done); else pass_cnt++;
        repeat (5) tick();
        chk_cnt++; if (aw_addr_log.size() !== 0) $display("FAIL empty_aw_count got=%0d exp=0", aw_addr_log.size()); else pass_cnt++;
        finish_run();
    endtask

    task automatic test_backpressure();
        bit to;
        logic [AW-1:0] s, e;
        int lasts;
        rand_bp = 1;
        for (int it = 0; it < 6; it++) begin
            s = AW'($urandom_range(0, 63)) * AW'(BL * BB);
            e = s + AW'($urandom_range(1, 40)) * AW'(BB);
            model_run(s, e);
            start_run(s, e, {$urandom, $urandom});
            wait_done(3000, to);
            chk_cnt++; if (to !== 1'b0) $display("FAIL bp_timeout[%0d] got=%0b exp=0", it, to); else pass_cnt++;
            chk_cnt++; if (w_data_log.size() !== exp_beats) $display("FAIL bp_beats[%0d] got=%0d exp=%0d", it, w_data_log.size(), exp_beats); else pass_cnt++;
            chk_cnt++; if (aw_addr_log.size() !== exp_addr.size()) $display("FAIL bp_aw_count[%0d] got=%0d exp=%0d", it, aw_addr_log.size(), exp_addr.size()); else pass_cnt++;
            for (int i = 0; i < exp_addr.size() && i < aw_addr_log.size(); i++) begin
                chk_cnt++; if (aw_addr_log[i] !== exp_addr[i] || aw_len_log[i] !== exp_len[i])
                    $display("FAIL bp_aw[%0d.%0d] got=%0h/%0d exp=%0h/%0d", it, i, aw_addr_log[i], aw_len_log[i], exp_addr[i], exp_len[i]);
                else pass_cnt++;
            end
            lasts = 0;
            foreach (w_last_log[i]) if (w_last_log[i]) lasts++;
            chk_cnt++; if (lasts !== exp_addr.size()) $display("FAIL bp_wlast_count[%0d] got=%0d exp=%0d", it, lasts, exp_addr.size()); else pass_cnt++;
            chk_cnt++; if (max_out > MO) $display("FAIL bp_peak[%0d] got=%0d exp<=%0d", it, max_out, MO); else pass_cnt++;
            finish_run();
        end
        rand_bp = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_burst();
        test_max_outstanding();
        test_pattern();
        test_abort();
        test_err();
        test_empty();
        test_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
